seq_bin2bcd_cgrundey: RTL and testbench

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 algorithm, one bit per clock. It generalises the fixed 6-bit combinational converter in the tx_rx_system datapath to any binary width, digit count and saturation limit. It adds a start/busy/done handshake so display and transmit logic can request conversions of wide counters without a deep combinational path. The active-low blanking input and all-ones "invalid" code are kept, so existing consumers decode results unchanged.

---
 rtl/seq_bin2bcd_cgrundey_if.sv | 24 ++
 rtl/seq_bin2bcd_cgrundey.sv | 110 +++++++++++
 tb/tb_seq_bin2bcd_cgrundey.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_bin2bcd_cgrundey_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// master drives the request; slave (the converter) returns status and result.
interface seq_bin2bcd_cgrundey_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic                  g_n;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, g_n, bin_in,
        input  busy, done, ovf, bcd_out
    );

    modport slave (
        input  start, g_n, bin_in,
        output busy, done, ovf, bcd_out
    );
endinterface

// File: rtl/seq_bin2bcd_cgrundey.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with blanking and saturation to an all-ones invalid code.
module seq_bin2bcd_cgrundey #(
    parameter int unsigned     BIN_W   = 8,
    parameter int unsigned     DIGITS  = 3,
    parameter longint unsigned MAX_VAL = 64'd10 ** DIGITS - 64'd1
) (
    input logic                   clk,
    input logic                   rst,
    seq_bin2bcd_cgrundey_if.slave bus
);
    localparam int unsigned SW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                blank_q, blank_d;
    logic                ovf_next_q, ovf_next_d;
    logic                ovf_q, ovf_d;
    logic [SW-1:0]       bcd_q, bcd_d;

    logic [SW-1:0]       adj;
    logic [SW+BIN_W-1:0] step;
    logic                too_big;
    logic                load;

    assign too_big = 64'(bus.bin_in) > MAX_VAL;

    // Per-digit +3 correction; wraps within the nibble, never carries.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        step = {adj, shift_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        blank_d    = blank_q;
        ovf_next_d = ovf_next_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: load = bus.start;
            StConv: begin
                scratch_d = step[SW+BIN_W-1 -: SW];
                shift_d   = step[BIN_W-1:0];
                cnt_d     = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = StDone;
                    bcd_d   = (blank_q || ovf_next_q) ? '1 : step[SW+BIN_W-1 -: SW];
                    ovf_d   = ovf_next_q & ~blank_q;
                end
            end
            StDone: begin
                load    = bus.start;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // DONE accepts a new request so held start gives back-to-back conversions.
        if (load) begin
            shift_d    = bus.bin_in;
            scratch_d  = '0;
            cnt_d      = 6'(BIN_W);
            blank_d    = bus.g_n;
            ovf_next_d = too_big;
            state_d    = StConv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            blank_q    <= 1'b0;
            ovf_next_q <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            blank_q    <= blank_d;
            ovf_next_q <= ovf_next_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.busy    = (state_q == StConv);
    assign bus.done    = (state_q == StDone);
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_seq_bin2bcd_cgrundey.sv
// Bench for seq_bin2bcd_cgrundey: default 8-bit/3-digit instance plus a legacy
// 6-bit/2-digit/max-39 instance, checked every cycle against an arithmetic model.
module tb_seq_bin2bcd_cgrundey;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  start_v = '0;
    logic [1:0]  gn_v    = '0;
    logic [31:0] bin_v [2];

    seq_bin2bcd_cgrundey_if #(.BIN_W(8), .DIGITS(3)) ifa ();
    seq_bin2bcd_cgrundey_if #(.BIN_W(6), .DIGITS(2)) ifb ();

    seq_bin2bcd_cgrundey #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    seq_bin2bcd_cgrundey #(.BIN_W(6), .DIGITS(2), .MAX_VAL(39)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    assign ifa.start  = start_v[0];
    assign ifa.g_n    = gn_v[0];
    assign ifa.bin_in = bin_v[0][7:0];
    assign ifb.start  = start_v[1];
    assign ifb.g_n    = gn_v[1];
    assign ifb.bin_in = bin_v[1][5:0];

    logic [1:0]  busy_w, done_w, ovf_w;
    logic [47:0] bcd_w [2];
    assign busy_w = {ifb.busy, ifa.busy};
    assign done_w = {ifb.done, ifa.done};
    assign ovf_w  = {ifb.ovf, ifa.ovf};
    assign bcd_w[0] = 48'(ifa.bcd_out);
    assign bcd_w[1] = 48'(ifb.bcd_out);

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int unsigned w_of(input int k);
        return (k == 0) ? 8 : 6;
    endfunction
    function automatic int unsigned d_of(input int k);
        return (k == 0) ? 3 : 2;
    endfunction
    function automatic int unsigned max_of(input int k);
        return (k == 0) ? 999 : 39;
    endfunction

    function automatic logic [47:0] ones(input int unsigned d);
        logic [47:0] r = '0;
        for (int i = 0; i < int'(4 * d); i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [47:0] to_bcd(input int unsigned v, input int unsigned d);
        logic [47:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < int'(d); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: a request takes BIN_W cycles, then the decimal value appears.
    logic [1:0]  m_busy, m_done, m_ovf;
    logic [47:0] m_bcd   [2];
    int unsigned m_rem   [2];
    int unsigned m_val   [2];
    logic        m_blank [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= '0;
            m_done <= '0;
            m_ovf  <= '0;
            for (int k = 0; k < 2; k++) begin
                m_bcd[k] <= ones(d_of(k));
                m_rem[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (m_busy[k]) begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_busy[k] <= 1'b0;
                        m_done[k] <= 1'b1;
                        m_ovf[k]  <= (m_val[k] > max_of(k)) && !m_blank[k];
                        m_bcd[k]  <= (m_blank[k] || m_val[k] > max_of(k)) ? ones(d_of(k))
                                                                         : to_bcd(m_val[k], d_of(k));
                    end
                end else if (start_v[k]) begin
                    m_busy[k]  <= 1'b1;
                    m_rem[k]   <= w_of(k);
                    m_val[k]   <= bin_v[k] & ((32'd1 << w_of(k)) - 1);
                    m_blank[k] <= gn_v[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cycle_dut%0d", k),
                    64'({busy_w[k], done_w[k], ovf_w[k], bcd_w[k]}),
                    64'({m_busy[k], m_done[k], m_ovf[k], m_bcd[k]}));
            end
        end
    end

    task automatic run_one(input int k, input int unsigned v, input logic gn,
                           input logic [47:0] eb, input logic eo, input int el,
                           input string nm);
        int n = 0;
        @(negedge clk);
        start_v[k] = 1'b1;
        bin_v[k]   = v;
        gn_v[k]    = gn;
        do begin
            @(negedge clk);
            n++;
            start_v[k] = 1'b0;
        end while (!done_w[k] && n < 40);
        chk({nm, "_latency"}, 64'(n), 64'(el));
        chk({nm, "_bcd"}, 64'(bcd_w[k]), 64'(eb));
        chk({nm, "_ovf"}, 64'(ovf_w[k]), 64'(eo));
        @(negedge clk);
        chk({nm, "_done_drop"}, 64'(done_w[k]), 64'd0);
    endtask

    initial begin
        int n;
        int dones;
        logic [47:0] seen;
        bin_v[0] = 0;
        bin_v[1] = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_state", 64'({busy_w[0], done_w[0], ovf_w[0], bcd_w[0]}),
            64'({3'b000, 48'hFFF}));
        rst = 1'b0;

        run_one(0, 255, 1'b0, 48'h255, 1'b0, 9, "a_255");

        // Back-to-back: start held, second operand swapped in at the first done.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 0;
        gn_v[0]    = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done_w[0] && n < 40);
        chk("b2b_first_bcd", 64'(bcd_w[0]), 64'h000);
        bin_v[0] = 99;
        n = 0;
        do begin @(negedge clk); n++; end while (!done_w[0] && n < 40);
        chk("b2b_gap", 64'(n), 64'd9);
        chk("b2b_second_bcd", 64'(bcd_w[0]), 64'h099);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);

        run_one(1, 39, 1'b0, 48'h39, 1'b0, 7, "b_39");
        run_one(1, 40, 1'b0, 48'hFF, 1'b1, 7, "b_40");
        run_one(1, 63, 1'b0, 48'hFF, 1'b1, 7, "b_63");
        run_one(0, 42, 1'b1, 48'hFFF, 1'b0, 9, "a_blank");

        // Start during busy is ignored.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 200;
        gn_v[0]    = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 17;
        gn_v[0]    = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        dones = 0;
        seen  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_w[0]) begin
                dones++;
                seen = bcd_w[0];
            end
        end
        chk("ignore_done_count", 64'(dones), 64'd1);
        chk("ignore_bcd", 64'(seen), 64'h200);

        // Asynchronous reset after the fourth iteration.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 100;
        gn_v[0]    = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_abort", 64'({busy_w[0], done_w[0], bcd_w[0]}), 64'({2'b00, 48'hFFF}));
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        chk("rst_no_done", 64'(dones), 64'd0);
        run_one(0, 100, 1'b0, 48'h100, 1'b0, 9, "after_rst");

        // Random traffic on both instances, checked by the per-cycle compare.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                start_v[k] = ($urandom_range(0, 3) == 0);
                gn_v[k]    = ($urandom_range(0, 7) == 0);
                bin_v[k]   = (k == 0) ? $urandom_range(0, 255) : $urandom_range(0, 63);
            end
        end
        start_v = '0;
        repeat (12) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
